cmp_share_arb: RTL and testbench
================================

Name: cmp_share_arb

Overview:
- Shares one 4-bit magnitude-compare datapath (a<b, a==b, a>b) between N requesters.
- Round-robin arbitration picks one requester and captures its operand pair.
- The compare is evaluated on the registered operands, and the one-hot result is returned to the requester with a valid/ready handshake tagged by requester id.
- Sits between client blocks and the shared compare resource; the compare logic is instantiated inside this block.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 4, operand width in bits
ID_W, 2, width of requester id (must be >= ceil(log2(N_REQ)))

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester request; held high until its gnt bit pulses
a_in  in  N_REQ*W  packed operand A; requester i uses bits [i*W +: W]
b_in  in  N_REQ*W  packed operand B; same packing as a_in
gnt  out  N_REQ  one-hot, one-cycle pulse: operands of that requester captured
busy  out  1  high whenever state != IDLE
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_id  out  ID_W  index of the requester whose result is presented
alb  out  1  captured A < captured B
aeb  out  1  captured A == captured B
agb  out  1  captured A > captured B

Behaviour:
- Interface (decided): single clock clk; reset rst_n is asynchronous, active-low. While rst_n=0 all flops are cleared:
  - state=IDLE, rr_ptr=0
  - gnt=0, busy=0, rsp_valid=0, rsp_id=0, alb=aeb=agb=0
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states IDLE, CMP, RESP:
  - IDLE: req is sampled only here. If req!=0, the winner is the first set bit searching upward from rr_ptr, wrapping at N_REQ-1 -> 0. On that edge:
    - op_a/op_b <= winner's slice; id <= winner
    - gnt <= one-hot(winner); rr_ptr <= (winner+1) mod N_REQ
    - state <= CMP
  - If req==0 in IDLE, hold state; gnt stays 0.
  - CMP: gnt <= 0. alb/aeb/agb <= compare(op_a, op_b), unsigned, exactly one high. rsp_id <= id; rsp_valid <= 1; state <= RESP.
  - RESP: rsp_valid stays 1 and rsp_id/alb/aeb/agb stay stable until an edge with rsp_ready=1. On that edge rsp_valid <= 0 and state <= IDLE.
- Result flags and rsp_id keep their last values after rsp_valid drops; consumers qualify them with rsp_valid.
- Latency:
  - req sampled at edge k -> gnt high in cycle k..k+1
  - rsp_valid rises at edge k+1
  - with rsp_ready tied high: accept at edge k+2, next grant at edge k+3 at the earliest
  - peak throughput: one compare per 3 cycles
- Requester rules:
  - Operands must be stable while req is high and until gnt is seen. They may change in the cycle after gnt.
  - A requester that keeps req high after its gnt is served again only after every other active requester, per the rr_ptr rotation.
- Boundary conditions:
  - rsp_ready high in CMP is ignored; acceptance happens only in RESP.
  - req changes while busy are ignored; req is re-evaluated on return to IDLE.
  - rr_ptr wraps N_REQ-1 -> 0.
  - Equal operands, including 0/0 and all-ones/all-ones, give aeb=1.
  - Reset asserted mid-transaction aborts it: no rsp_valid is produced for the captured request and rr_ptr returns to 0.
- Invariants (checked by assertions):
  - gnt is one-hot or zero, and never high outside the cycle after an IDLE grant.
  - When rsp_valid=1, exactly one of alb/aeb/agb is 1.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> gnt=0, rsp_valid=0, busy=0, all flags 0. Release rst_n -> first grant goes to requester 0.
- Single request: req[2]=1 with a=4'b1100, b=4'b0011, rsp_ready=1 -> gnt=4'b0100 one cycle later; next cycle rsp_valid=1, rsp_id=2, agb=1, alb=0, aeb=0. Then requester 2 is swapped to a=0011, b=1100 (alb=1), then a=0000, b=0000 (aeb=1).
- Round robin: req=4'b1111 held, distinct operands per requester -> grant order 0,1,2,3,0; each rsp_id matches its grant; grants spaced 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises, a=9, b=9, req[1] pending -> rsp_valid, rsp_id and aeb=1 stay stable; busy=1; no new gnt. rsp_ready=1 -> accept, and gnt[1] fires 1 cycle after return to IDLE.
- Wrap and skip: rr_ptr=3 with req=4'b0101 -> grant to 0, then 2.
- Reset mid-operation: assert rst_n=0 during RESP -> rsp_valid drops immediately (asynchronous). After release, state is IDLE and rr_ptr=0.

Source files
------------

// File: rtl/cmp_share_arb_if.sv
// Bundle of request/operand/grant and result handshake signals between the
// client side (master) and the shared compare arbiter (slave).
interface cmp_share_arb_if #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] a_in;
  logic [N_REQ*W-1:0] b_in;
  logic [N_REQ-1:0]   gnt;
  logic               busy;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic               alb;
  logic               aeb;
  logic               agb;

  modport master (
    output req, a_in, b_in, rsp_ready,
    input  gnt, busy, rsp_valid, rsp_id, alb, aeb, agb
  );

  modport slave (
    input  req, a_in, b_in, rsp_ready,
    output gnt, busy, rsp_valid, rsp_id, alb, aeb, agb
  );
endinterface

// File: rtl/cmp_share_arb.sv
// Round-robin arbiter sharing one unsigned magnitude comparator between
// N_REQ requesters; the result returns on a valid/ready handshake tagged by id.
module cmp_share_arb #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  cmp_share_arb_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_r;
  logic [ID_W-1:0]    rr_ptr_r;
  logic [W-1:0]       op_a_r;
  logic [W-1:0]       op_b_r;
  logic [ID_W-1:0]    id_r;
  logic [N_REQ-1:0]   gnt_r;
  logic               busy_r;
  logic               rsp_valid_r;
  logic [ID_W-1:0]    rsp_id_r;
  logic               alb_r;
  logic               aeb_r;
  logic               agb_r;

  logic [2*N_REQ-1:0] req_dbl_s;
  logic [N_REQ-1:0]   req_rot_s;
  logic               win_found_s;
  logic [ID_W-1:0]    win_idx_s;
  logic [N_REQ-1:0]   win_oh_s;
  logic [W-1:0]       win_a_s;
  logic [W-1:0]       win_b_s;
  logic [ID_W-1:0]    nxt_ptr_s;

  // Returns {a<b, a==b, a>b}; exactly one bit is set.
  function automatic logic [2:0] mag_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2:0] r;
    if (a < b) begin
      r = 3'b100;
    end else if (a == b) begin
      r = 3'b010;
    end else begin
      r = 3'b001;
    end
    return r;
  endfunction

  // Winner search: rotate req so rr_ptr lands at bit 0, take the lowest set bit.
  always_comb begin : pick
    int off_v;
    int sum_v;
    req_dbl_s   = {bus.req, bus.req} >> rr_ptr_r;
    req_rot_s   = req_dbl_s[N_REQ-1:0];
    win_found_s = |req_rot_s;
    off_v       = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      off_v = req_rot_s[i] ? i : off_v;
    end
    sum_v = int'(rr_ptr_r) + off_v;
    if (sum_v >= N_REQ) begin
      sum_v = sum_v - N_REQ;
    end else begin
      sum_v = sum_v + 0;
    end
    win_idx_s = ID_W'(sum_v);
    win_oh_s  = '0;
    win_a_s   = '0;
    win_b_s   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (win_idx_s == ID_W'(j)) begin
        win_oh_s[j] = win_found_s;
        win_a_s     = bus.a_in[j*W +: W];
        win_b_s     = bus.b_in[j*W +: W];
      end else begin
        win_oh_s[j] = 1'b0;
      end
    end
    if (win_idx_s == ID_W'(N_REQ - 1)) begin
      nxt_ptr_s = '0;
    end else begin
      nxt_ptr_s = win_idx_s + ID_W'(1);
    end
  end

  // Control FSM with all outputs held in registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      op_a_r      <= '0;
      op_b_r      <= '0;
      id_r        <= '0;
      gnt_r       <= '0;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      alb_r       <= 1'b0;
      aeb_r       <= 1'b0;
      agb_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (win_found_s) begin
            op_a_r   <= win_a_s;
            op_b_r   <= win_b_s;
            id_r     <= win_idx_s;
            gnt_r    <= win_oh_s;
            rr_ptr_r <= nxt_ptr_s;
            busy_r   <= 1'b1;
            state_r  <= CMP;
          end else begin
            gnt_r <= '0;
          end
        end
        CMP: begin
          gnt_r                 <= '0;
          {alb_r, aeb_r, agb_r} <= mag_cmp(op_a_r, op_b_r);
          rsp_id_r              <= id_r;
          rsp_valid_r           <= 1'b1;
          state_r               <= RESP;
        end
        RESP: begin
          // Result stays presented until the consumer takes it.
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          gnt_r       <= '0;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.busy      = busy_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.alb       = alb_r;
  assign bus.aeb       = aeb_r;
  assign bus.agb       = agb_r;

  cmp_share_arb_chk #(.N_REQ(N_REQ)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .gnt       (gnt_r),
    .busy      (busy_r),
    .rsp_valid (rsp_valid_r),
    .alb       (alb_r),
    .aeb       (aeb_r),
    .agb       (agb_r)
  );

endmodule

// Invariant checker for the grant pulse and the one-hot result flags.
module cmp_share_arb_chk #(
  parameter int N_REQ = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic [N_REQ-1:0] gnt,
  input logic             busy,
  input logic             rsp_valid,
  input logic             alb,
  input logic             aeb,
  input logic             agb
);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

  // A grant only appears in the cycle right after an IDLE capture.
  a_gnt_ctx: assert property (@(posedge clk) disable iff (!rst_n)
    (gnt != '0) |-> (busy && !rsp_valid));

  a_gnt_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    (gnt != '0) |=> (gnt == '0));

  a_flags: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid |-> $onehot({alb, aeb, agb}));

endmodule

// File: tb/tb_cmp_share_arb.sv
// Directed bench for cmp_share_arb: transaction-level reference model checked
// every cycle, plus hand-computed literal checks at key points.
module tb_cmp_share_arb;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  cmp_share_arb_if #(.N_REQ(4), .W(4), .ID_W(2)) bus ();

  cmp_share_arb #(.N_REQ(4), .W(4), .ID_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arbitration: first requester at or after ptr, going round.
  function automatic int rr_pick(input logic [3:0] r, input int ptr);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = (ptr + k) % 4;
      if (r[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic int slice4(input logic [15:0] v, input int i);
    return int'(v >> (4 * i)) & 15;
  endfunction

  function automatic int oh2i(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Model: each transaction lives through grant -> presented -> accepted.
  int m_stage = 0;   // 0 free, 1 granted, 2 result presented
  int m_ptr   = 0;
  int m_id    = 0;
  int m_a     = 0;
  int m_b     = 0;
  int m_pick;
  int e_gnt   = 0;
  int e_busy  = 0;
  int e_valid = 0;
  int e_id    = 0;
  int e_flags = 0;

  always_comb m_pick = rr_pick(bus.req, m_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stage <= 0; m_ptr <= 0; m_id <= 0; m_a <= 0; m_b <= 0;
      e_gnt <= 0; e_busy <= 0; e_valid <= 0; e_id <= 0; e_flags <= 0;
    end else if (m_stage == 0) begin
      if (m_pick >= 0) begin
        e_gnt   <= 1 << m_pick;
        e_busy  <= 1;
        m_id    <= m_pick;
        m_a     <= slice4(bus.a_in, m_pick);
        m_b     <= slice4(bus.b_in, m_pick);
        m_ptr   <= (m_pick + 1) % 4;
        m_stage <= 1;
      end else begin
        e_gnt <= 0;
      end
    end else if (m_stage == 1) begin
      e_gnt   <= 0;
      e_valid <= 1;
      e_id    <= m_id;
      e_flags <= (m_a < m_b) ? 4 : ((m_a == m_b) ? 2 : 1);
      m_stage <= 2;
    end else if (bus.rsp_ready) begin
      e_valid <= 0;
      e_busy  <= 0;
      m_stage <= 0;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("m_gnt",   int'(bus.gnt), e_gnt);
    chk("m_busy",  int'(bus.busy), e_busy);
    chk("m_valid", int'(bus.rsp_valid), e_valid);
    chk("m_id",    int'(bus.rsp_id), e_id);
    chk("m_flags", int'({bus.alb, bus.aeb, bus.agb}), e_flags);
  end

  task automatic set_op(input int i, input int a, input int b);
    for (int j = 0; j < 4; j++) begin
      if (j == i) begin
        bus.a_in[j*4 +: 4] = a[3:0];
        bus.b_in[j*4 +: 4] = b[3:0];
      end
    end
  endtask

  task automatic wait_gnt();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.gnt != 4'b0000) return;
    end
    chk("gnt_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic do_single(input int a, input int b, input int exp_flags);
    set_op(2, a, b);
    bus.req = 4'b0100;
    wait_gnt();
    chk("single_gnt", int'(bus.gnt), 4);
    bus.req = 4'b0000;
    @(negedge clk);
    chk("single_valid", int'(bus.rsp_valid), 1);
    chk("single_id",    int'(bus.rsp_id), 2);
    chk("single_flags", int'({bus.alb, bus.aeb, bus.agb}), exp_flags);
    wait_idle();
  endtask

  int glog[$];
  int gcyc[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end (tests %0d)", n_tests);
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.req       = 4'b1111;
    bus.a_in      = 16'h0;
    bus.b_in      = 16'h0;
    bus.rsp_ready = 1'b1;
    set_op(0, 1, 2);
    set_op(1, 5, 5);
    set_op(2, 15, 0);
    set_op(3, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_gnt",   int'(bus.gnt), 0);
    chk("rst_valid", int'(bus.rsp_valid), 0);
    chk("rst_busy",  int'(bus.busy), 0);
    chk("rst_flags", int'({bus.alb, bus.aeb, bus.agb}), 0);
    rst_n = 1'b1;

    // Round robin with all requesters held high.
    for (int i = 0; i < 40 && glog.size() < 5; i++) begin
      @(negedge clk);
      if (bus.gnt != 4'b0000) begin
        glog.push_back(oh2i(bus.gnt));
        gcyc.push_back(cyc);
      end
    end
    bus.req = 4'b0000;
    chk("rr_count", glog.size(), 5);
    if (glog.size() == 5) begin
      chk("rr_ord0", glog[0], 0);
      chk("rr_ord1", glog[1], 1);
      chk("rr_ord2", glog[2], 2);
      chk("rr_ord3", glog[3], 3);
      chk("rr_ord4", glog[4], 0);
      for (int i = 0; i < 4; i++) chk("rr_space", gcyc[i+1] - gcyc[i], 3);
    end
    wait_idle();

    // Single requester, several operand patterns.
    do_single(12, 3, 1);
    do_single(3, 12, 4);
    do_single(0, 0, 2);
    do_single(15, 15, 2);

    // Backpressure with a second request arriving while busy.
    bus.rsp_ready = 1'b0;
    set_op(3, 9, 9);
    bus.req = 4'b1000;
    wait_gnt();
    chk("bp_gnt", int'(bus.gnt), 8);
    bus.req = 4'b0010;
    set_op(1, 4, 7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", int'(bus.rsp_valid), 1);
      chk("bp_id",    int'(bus.rsp_id), 3);
      chk("bp_flags", int'({bus.alb, bus.aeb, bus.agb}), 2);
      chk("bp_busy",  int'(bus.busy), 1);
      chk("bp_nognt", int'(bus.gnt), 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept", int'(bus.rsp_valid), 0);
    chk("bp_idle",   int'(bus.busy), 0);
    @(negedge clk);
    chk("bp_next_gnt", int'(bus.gnt), 2);
    bus.req = 4'b0000;
    wait_idle();

    // Move rr_ptr to 3, then wrap and skip.
    do_single(5, 5, 2);
    glog.delete();
    set_op(0, 7, 8);
    set_op(2, 8, 7);
    bus.req = 4'b0101;
    for (int i = 0; i < 20 && glog.size() < 2; i++) begin
      @(negedge clk);
      if (bus.gnt != 4'b0000) glog.push_back(oh2i(bus.gnt));
    end
    bus.req = 4'b0000;
    chk("wrap_count", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("wrap_first",  glog[0], 0);
      chk("wrap_second", glog[1], 2);
    end
    wait_idle();

    // Reset in the middle of a response.
    bus.rsp_ready = 1'b0;
    set_op(0, 2, 2);
    bus.req = 4'b0001;
    wait_gnt();
    bus.req = 4'b0000;
    @(negedge clk);
    chk("mid_valid_pre", int'(bus.rsp_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_valid_drop", int'(bus.rsp_valid), 0);
    chk("mid_busy_drop",  int'(bus.busy), 0);
    repeat (2) @(negedge clk);
    bus.req = 4'b1001;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_ptr_zero", int'(bus.gnt), 1);
    bus.req = 4'b0000;
    bus.rsp_ready = 1'b1;
    wait_idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
